// File: rtl/vga_timing_pkg.sv
// Shared timing constants, per-stage flag bundle and counter-width helper for vga_timing_gen.
// Start-of-line/frame markers exist only when VGA_TIMING_SOF_EN is defined.
package vga_timing_pkg;

   localparam int DEF_H_DISP  = 640;
   localparam int DEF_H_FP    = 16;
   localparam int DEF_H_PULSE = 96;
   localparam int DEF_H_BP    = 48;
   localparam int DEF_V_DISP  = 480;
   localparam int DEF_V_FP    = 10;
   localparam int DEF_V_PULSE = 2;
   localparam int DEF_V_BP    = 33;

   // Sync flags are carried as "active" bits; polarity is applied only at the pins.
   typedef struct packed {
      logic video;
      logic hs;
      logic vs;
`ifdef VGA_TIMING_SOF_EN
      logic sol;
      logic sof;
`endif
   } vga_flags_t;

   function automatic int cnt_width(input int h_total, input int v_total);
      int m;
      m = (h_total > v_total) ? h_total : v_total;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated, asynchronously reset register chain of DEPTH stages, each W bits wide.
module vga_delay_line #(
   parameter int           W       = 8,
   parameter int           DEPTH   = 2,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stg [DEPTH];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) stg[i] <= RST_VAL;
      end else if (en) begin
         stg[0] <= d;
         for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
      end
   end

   assign q = stg[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters, sync/video decode, and a PIPE-deep aligned output pipeline.
// Define VGA_TIMING_SOF_EN to generate o_sol/o_sof; otherwise they are tied low.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_DISP  = DEF_H_DISP,
   parameter int   H_FP    = DEF_H_FP,
   parameter int   H_PULSE = DEF_H_PULSE,
   parameter int   H_BP    = DEF_H_BP,
   parameter int   V_DISP  = DEF_V_DISP,
   parameter int   V_FP    = DEF_V_FP,
   parameter int   V_PULSE = DEF_V_PULSE,
   parameter int   V_BP    = DEF_V_BP,
   parameter logic HS_POL  = 1'b0,
   parameter logic VS_POL  = 1'b0,
   parameter int   CNT_W   = 12,
   parameter int   PIPE    = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_pix_en,
   output logic [CNT_W-1:0] o_x,
   output logic [CNT_W-1:0] o_y,
   output logic             o_video,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic             o_sol,
   output logic             o_sof
);

   localparam int H_TOTAL = H_DISP + H_FP + H_PULSE + H_BP;
   localparam int V_TOTAL = V_DISP + V_FP + V_PULSE + V_BP;

   localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_DISP_C    = CNT_W'(H_DISP);
   localparam logic [CNT_W-1:0] V_DISP_C    = CNT_W'(V_DISP);
   localparam logic [CNT_W-1:0] H_SYNC_FST  = CNT_W'(H_DISP + H_FP);
   localparam logic [CNT_W-1:0] H_SYNC_LST  = CNT_W'(H_DISP + H_FP + H_PULSE - 1);
   localparam logic [CNT_W-1:0] V_SYNC_FST  = CNT_W'(V_DISP + V_FP);
   localparam logic [CNT_W-1:0] V_SYNC_LST  = CNT_W'(V_DISP + V_FP + V_PULSE - 1);

   generate
      if (PIPE < 1 || PIPE > 4) begin : g_bad_pipe
         $error("vga_timing_gen: PIPE must be within 1..4");
      end
      if (cnt_width(H_TOTAL, V_TOTAL) > CNT_W) begin : g_bad_width
         $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
      end
   endgenerate

   // One pipeline stage; x/y width follows CNT_W so it is declared here.
   typedef struct packed {
      logic [CNT_W-1:0] x;
      logic [CNT_W-1:0] y;
      vga_flags_t       f;
   } stage_t;

   localparam stage_t STAGE_IDLE = '0;

   logic [CNT_W-1:0] hc;
   logic [CNT_W-1:0] vc;
   stage_t           cur;
   stage_t           last;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         hc <= '0;
         vc <= '0;
      end else if (i_pix_en) begin
         if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
         end else begin
            hc <= hc + 1'b1;
         end
      end
   end

   always_comb begin
      cur          = STAGE_IDLE;
      cur.x        = hc;
      cur.y        = vc;
      cur.f.video  = (hc < H_DISP_C) && (vc < V_DISP_C);
      cur.f.hs     = (hc >= H_SYNC_FST) && (hc <= H_SYNC_LST);
      cur.f.vs     = (vc >= V_SYNC_FST) && (vc <= V_SYNC_LST);
`ifdef VGA_TIMING_SOF_EN
      cur.f.sol    = (hc == '0);
      cur.f.sof    = (hc == '0) && (vc == '0);
`endif
   end

   vga_delay_line #(
      .W       ($bits(stage_t)),
      .DEPTH   (PIPE),
      .RST_VAL (STAGE_IDLE)
   ) u_pipe (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .en    (i_pix_en),
      .d     (cur),
      .q     (last)
   );

   assign o_x     = last.x;
   assign o_y     = last.y;
   assign o_video = last.f.video;
   assign o_hsync = last.f.hs ? HS_POL : ~HS_POL;
   assign o_vsync = last.f.vs ? VS_POL : ~VS_POL;
`ifdef VGA_TIMING_SOF_EN
   assign o_sol   = last.f.sol;
   assign o_sof   = last.f.sof;
`else
   assign o_sol   = 1'b0;
   assign o_sof   = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (PIPE 2/1/4, PIPE=4 with active-high syncs) on a small mode.
// Expected outputs come from the enabled-edge count since reset, mapped to raster coordinates arithmetically.
module tb_vga_timing_gen;

   localparam int HD = 16, HF = 4, HP = 6, HB = 6;
   localparam int VD = 10, VF = 2, VP = 3, VB = 4;
   localparam int HT = HD + HF + HP + HB;
   localparam int VT = VD + VF + VP + VB;
   localparam int FRAME = HT * VT;
   localparam int CW = 12;
   localparam int VW = 2 * CW + 5;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   logic i_pix_en = 1'b0;

   always #5 i_clk = ~i_clk;

   logic [CW-1:0] m_x, m_y, a_x, a_y, b_x, b_y;
   logic m_video, m_hs, m_vs, m_sol, m_sof;
   logic a_video, a_hs, a_vs, a_sol, a_sof;
   logic b_video, b_hs, b_vs, b_sol, b_sof;

   vga_timing_gen #(
      .H_DISP(HD), .H_FP(HF), .H_PULSE(HP), .H_BP(HB),
      .V_DISP(VD), .V_FP(VF), .V_PULSE(VP), .V_BP(VB),
      .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CW), .PIPE(2)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_pix_en(i_pix_en),
      .o_x(m_x), .o_y(m_y), .o_video(m_video), .o_hsync(m_hs), .o_vsync(m_vs),
      .o_sol(m_sol), .o_sof(m_sof)
   );

   vga_timing_gen #(
      .H_DISP(HD), .H_FP(HF), .H_PULSE(HP), .H_BP(HB),
      .V_DISP(VD), .V_FP(VF), .V_PULSE(VP), .V_BP(VB),
      .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CW), .PIPE(1)
   ) dut_p1 (
      .i_clk(i_clk), .i_rst(i_rst), .i_pix_en(i_pix_en),
      .o_x(a_x), .o_y(a_y), .o_video(a_video), .o_hsync(a_hs), .o_vsync(a_vs),
      .o_sol(a_sol), .o_sof(a_sof)
   );

   vga_timing_gen #(
      .H_DISP(HD), .H_FP(HF), .H_PULSE(HP), .H_BP(HB),
      .V_DISP(VD), .V_FP(VF), .V_PULSE(VP), .V_BP(VB),
      .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(CW), .PIPE(4)
   ) dut_p4 (
      .i_clk(i_clk), .i_rst(i_rst), .i_pix_en(i_pix_en),
      .o_x(b_x), .o_y(b_y), .o_video(b_video), .o_hsync(b_hs), .o_vsync(b_vs),
      .o_sol(b_sol), .o_sof(b_sof)
   );

   logic [3*VW-1:0] act_all;
   assign act_all = {m_x, m_y, m_video, m_hs, m_vs, m_sol, m_sof,
                     a_x, a_y, a_video, a_hs, a_vs, a_sol, a_sof,
                     b_x, b_y, b_video, b_hs, b_vs, b_sol, b_sof};

   int n;       // enabled edges seen since the last reset release
   int tests;
   int fails;

   // Output seen after cnt enabled edges for a given depth/polarity.
   function automatic logic [VW-1:0] exp_vec(input int cnt, input int p, input logic hp, input logic vp);
      int k, x, y;
      logic vid, hs, vs, sol, sof;
      if (cnt < p) return {CW'(0), CW'(0), 1'b0, ~hp, ~vp, 2'b00};
      k   = cnt - p;
      x   = k % HT;
      y   = (k / HT) % VT;
      vid = (x < HD) && (y < VD);
      hs  = (x >= HD + HF && x < HD + HF + HP) ? hp : ~hp;
      vs  = (y >= VD + VF && y < VD + VF + VP) ? vp : ~vp;
`ifdef VGA_TIMING_SOF_EN
      sol = (x == 0);
      sof = (x == 0) && (y == 0);
`else
      sol = 1'b0;
      sof = 1'b0;
`endif
      return {CW'(x), CW'(y), vid, hs, vs, sol, sof};
   endfunction

   function automatic logic [3*VW-1:0] exp_all(input int cnt);
      return {exp_vec(cnt, 2, 1'b0, 1'b0), exp_vec(cnt, 1, 1'b0, 1'b0), exp_vec(cnt, 4, 1'b1, 1'b1)};
   endfunction

   // Drive enable, take one clock edge, settle to 2ns after it.
   task automatic tick(input logic en);
      i_pix_en = en;
      @(posedge i_clk);
      if (en && !i_rst) n++;
      #2;
   endtask

   task automatic pulse_reset();
      i_rst = 1'b1;
      n = 0;
      @(posedge i_clk);
      #2;
      i_rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [3*VW-1:0] e;
      i_rst = 1'b1;
      i_pix_en = 1'b1;
      n = 0;
      repeat (3) @(posedge i_clk);
      #2;
      e = exp_all(0);
      tests++;
      if (act_all !== e) begin
         fails++;
         $display("FAIL reset_outputs: got %h expected %h", act_all, e);
      end
      tests++;
      if ({b_hs, b_vs, m_hs, m_vs} !== 4'b0011) begin
         fails++;
         $display("FAIL reset_sync_levels: got %b expected 0011", {b_hs, b_vs, m_hs, m_vs});
      end
      i_rst = 1'b0;
   endtask

   task automatic test_continuous();
      int run, vid_cnt, last_sol, last_sof;
      logic prev_hs;
      logic [3*VW-1:0] e;
      run = 0; vid_cnt = 0; last_sol = -1; last_sof = -1;
      prev_hs = m_hs;
      for (int c = 0; c < 2 * FRAME + 40; c++) begin
         tick(1'b1);
         e = exp_all(n);
         tests++;
         if (act_all !== e) begin
            fails++;
            $display("FAIL cont_model n=%0d: got %h expected %h", n, act_all, e);
         end
         if (m_hs === 1'b0) begin
            if (prev_hs === 1'b1) begin
               tests++;
               if (m_x !== CW'(HD + HF)) begin
                  fails++;
                  $display("FAIL hsync_start: got x=%0d expected %0d", m_x, HD + HF);
               end
            end
            run++;
         end else if (prev_hs === 1'b0 && run > 0) begin
            tests++;
            if (run != HP) begin
               fails++;
               $display("FAIL hsync_width: got %0d expected %0d", run, HP);
            end
            run = 0;
         end
         prev_hs = m_hs;
         if (c >= FRAME && c < 2 * FRAME && m_video === 1'b1) vid_cnt++;
         if (c >= 4 && m_x === CW'(0)) begin
            if (last_sol >= 0) begin
               tests++;
               if (c - last_sol != HT) begin
                  fails++;
                  $display("FAIL line_period: got %0d expected %0d", c - last_sol, HT);
               end
            end
            last_sol = c;
            if (m_y === CW'(0)) begin
               if (last_sof >= 0) begin
                  tests++;
                  if (c - last_sof != FRAME) begin
                     fails++;
                     $display("FAIL frame_period: got %0d expected %0d", c - last_sof, FRAME);
                  end
               end
               last_sof = c;
            end
         end
      end
      tests++;
      if (vid_cnt != HD * VD) begin
         fails++;
         $display("FAIL video_count: got %0d expected %0d", vid_cnt, HD * VD);
      end
   endtask

   task automatic test_pipe_latency();
      int f_m, f_a, f_b;
      f_m = -1; f_a = -1; f_b = -1;
      pulse_reset();
      for (int c = 1; c <= 8; c++) begin
         tick(1'b1);
         if (f_m < 0 && m_video === 1'b1) f_m = c;
         if (f_a < 0 && a_video === 1'b1) f_a = c;
         if (f_b < 0 && b_video === 1'b1) f_b = c;
      end
      tests++;
      if (f_a != 1) begin fails++; $display("FAIL latency_pipe1: got %0d expected 1", f_a); end
      tests++;
      if (f_m != 2) begin fails++; $display("FAIL latency_pipe2: got %0d expected 2", f_m); end
      tests++;
      if (f_b != 4) begin fails++; $display("FAIL latency_pipe4: got %0d expected 4", f_b); end
   endtask

   task automatic test_pattern_100();
      int last_line, sof_run;
      logic prev_x0;
      logic [3*VW-1:0] e;
      last_line = -1; sof_run = 0;
      pulse_reset();
      prev_x0 = 1'b0;
      for (int c = 0; c < 3 * FRAME + 30; c++) begin
         tick((c % 3) == 0);
         e = exp_all(n);
         tests++;
         if (act_all !== e) begin
            fails++;
            $display("FAIL pattern_model n=%0d: got %h expected %h", n, act_all, e);
         end
         if (c >= 12 && m_x === CW'(0) && !prev_x0) begin
            if (last_line >= 0) begin
               tests++;
               if (c - last_line != 3 * HT) begin
                  fails++;
                  $display("FAIL pattern_line_period: got %0d expected %0d", c - last_line, 3 * HT);
               end
            end
            last_line = c;
         end
         prev_x0 = (m_x === CW'(0));
`ifdef VGA_TIMING_SOF_EN
         if (m_sof === 1'b1) sof_run++;
         else if (sof_run > 0) begin
            tests++;
            if (sof_run != 3) begin
               fails++;
               $display("FAIL pattern_sof_width: got %0d expected 3", sof_run);
            end
            sof_run = 0;
         end
`else
         if (m_sof === 1'b1) sof_run++;
`endif
      end
`ifndef VGA_TIMING_SOF_EN
      tests++;
      if (sof_run != 0) begin
         fails++;
         $display("FAIL sof_disabled: got %0d high cycles expected 0", sof_run);
      end
`endif
   endtask

   task automatic test_random_en();
      logic [3*VW-1:0] e;
      pulse_reset();
      for (int c = 0; c < 1500; c++) begin
         tick(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
         e = exp_all(n);
         tests++;
         if (act_all !== e) begin
            fails++;
            $display("FAIL random_model n=%0d: got %h expected %h", n, act_all, e);
         end
      end
   endtask

   task automatic test_mid_reset();
      int target, guard;
      logic [3*VW-1:0] e;
      target = 2 + 6 * HT + 10;
      guard = 0;
      pulse_reset();
      while (n < target && guard < 2 * FRAME) begin
         tick(1'b1);
         guard++;
      end
      tests++;
      if (m_x !== CW'(10) || m_y !== CW'(6)) begin
         fails++;
         $display("FAIL midreset_reach: got x=%0d y=%0d expected 10,6", m_x, m_y);
      end
      #3;
      i_rst = 1'b1;
      n = 0;
      #1;
      e = exp_all(0);
      tests++;
      if (act_all !== e) begin
         fails++;
         $display("FAIL midreset_async: got %h expected %h", act_all, e);
      end
      @(posedge i_clk);
      #2;
      i_rst = 1'b0;
      for (int c = 0; c < 100; c++) begin
         tick(1'b1);
         e = exp_all(n);
         tests++;
         if (act_all !== e) begin
            fails++;
            $display("FAIL midreset_restart n=%0d: got %h expected %h", n, act_all, e);
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      n = 0;
      test_reset();
      test_continuous();
      test_pipe_latency();
      test_pattern_100();
      test_random_en();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
